rob_wb_arbiter: RTL and testbench
=================================

# rob_wb_arbiter

Writeback arbiter between the functional units and the reorder buffer's write ports. Each cycle it selects up to WR_PORTS completing functional-unit results, using a rotating round-robin priority, and packs them into the ROB write interface (write_slot/write_valid/write_data) through one register stage. It sits between the execute stage and `rob`. The ROB accepts every write, so the arbiter is the only point of writeback backpressure.

## Interface
- NUM_FU, 6: number of requesting functional units (2..16).
- WR_PORTS, 4: ROB write ports driven (1..NUM_FU).
- SLOT_W, 4: ROB slot index width.
- T, logic [31:0]: result payload type.

- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush; synchronous.
- fu_valid  in  [NUM_FU]  result pending from FU i.
- fu_slot  in  [NUM_FU] x SLOT_W  ROB slot of FU i's result.
- fu_data  in  [NUM_FU] x T  result of FU i.
- fu_ready  out  [NUM_FU]  FU i's result accepted this cycle.
- write_slot  out  [WR_PORTS] x SLOT_W  to ROB write_slot.
- write_valid  out  [WR_PORTS]  to ROB write_valid.
- write_data  out  [WR_PORTS] x T  to ROB write_data.

## Operation
- Handshake: a transfer occurs when fu_valid[i] and fu_ready[i] are both high at a rising edge.
  - fu_valid must not depend on fu_ready.
  - fu_ready is combinational from fu_valid, rr_ptr and flush.
  - An FU holds valid/slot/data stable until it is accepted.
- Selection: scan indices rr_ptr, rr_ptr+1, … mod NUM_FU. The first WR_PORTS indices with fu_valid=1 are granted.
- Packing: the k-th granted FU, in scan order, goes to port k. Ports at and above the grant count have write_valid=0.
- rr_ptr update:
  - Any grant: rr_ptr <= (last granted index + 1) mod NUM_FU.
  - No grant: rr_ptr is unchanged.
  - rr_ptr width is $clog2(NUM_FU). The wrap is explicit, and is required when NUM_FU is not a power of two.
- Starvation bound: a continuously valid FU is granted within ceil(NUM_FU/WR_PORTS) cycles.
- flush=1:
  - All fu_ready are 0; no grants are made.
  - Next cycle, all write_valid are 0 and rr_ptr is 0.
  - A flush takes precedence over any pending grants in the same cycle.
- Duplicate slots are not checked. Slot uniqueness is the allocator's guarantee.

## Timing
- Reset values:
  - write_valid all 0, write_slot all 0, write_data all 0, rr_ptr 0.
  - fu_ready follows fu_valid combinationally; with no valid inputs, all fu_ready are 0.
- Reset assertion clears the registers immediately (asynchronous), including mid-transfer. A handshake in flight at that point is lost.
- Latency: handshake at edge N, so write_valid/slot/data are presented during cycle N to N+1 and written into the ROB at edge N+1.
- Throughput: WR_PORTS results per cycle, sustained.
- Output registers reload every cycle. write_valid falls the cycle after no grants; slot and data may hold stale values while write_valid=0.

## Configuration
- Macro ROB_WB_STATS_EN.
- Defined: adds two outputs.
  - stat_writes (32-bit): increments by the grant count each cycle.
  - stat_stalls (32-bit): increments by 1 in each cycle where the number of valid FUs exceeds WR_PORTS and flush=0.
  - Both wrap modulo 2^32, are cleared by reset, and are not cleared by flush.
- Undefined: the ports and counters are absent. Arbitration behaviour is identical.

## Structure
- Shared package rob_pkg: rob_slot_t (logic [SLOT_W-1:0]) and constant ROB_WR_PORTS = 4. Both are shared with `rob` and the allocator.
- Sub-module rob_wb_select: purely combinational round-robin picker.
  - Inputs: fu_valid, rr_ptr.
  - Outputs: grant vector, per-port FU index, port-valid vector, next_ptr.
- The top level holds rr_ptr, the output registers and the stats counters.

## Test plan
- Reset: assert reset with fu_valid=6'b111111 → write_valid=0 immediately. After release, the first grant is FUs 0–3.
- Single request: fu_valid[2]=1, slot 5, data 0xA5, rr_ptr=0 → fu_ready=6'b000100 in the same cycle. Next cycle write_valid=4'b0001, write_slot[0]=5, write_data[0]=0xA5. rr_ptr becomes 3.
- Oversubscription: all 6 valid for two cycles, starting rr_ptr=0.
  - Cycle 1 grants FUs 0,1,2,3 on ports 0..3; rr_ptr=4.
  - Cycle 2 grants FUs 4,5,0,1 on ports 0..3; rr_ptr=2.
  - With ROB_WB_STATS_EN: stat_stalls=2 and stat_writes=8.
- Wrap packing: rr_ptr=4, fu_valid=6'b100011 → ports 0,1,2 carry FUs 5,0,1; write_valid=4'b0111; rr_ptr becomes 2.
- Flush: three FUs valid and flush=1 → fu_ready=0. Next cycle write_valid=0 and rr_ptr=0. The FUs are granted after flush drops.
- Random soak: FUs complete after random delays; a checker compares every ROB write against the FU-side log. Requirements:
  - No loss and no duplication of results.
  - No FU waits more than 2 cycles while continuously valid (NUM_FU=6, WR_PORTS=4).

Source files
------------

// File: rtl/rob_pkg.sv
// Types and constants shared by the ROB, the slot allocator and the writeback arbiter.
package rob_pkg;

  localparam int ROB_SLOT_W   = 4;
  localparam int ROB_WR_PORTS = 4;

  typedef logic [ROB_SLOT_W-1:0] rob_slot_t;

endpackage

// File: rtl/rob_wb_select.sv
// Combinational round-robin picker: grants up to WR_PORTS valid FUs starting at i_rr_ptr
// and reports which FU lands on each write port, in scan order.
module rob_wb_select
  import rob_pkg::*;
#(
  parameter int NUM_FU   = 6,
  parameter int WR_PORTS = ROB_WR_PORTS,
  localparam int PTR_W   = $clog2(NUM_FU)
) (
  input  logic [NUM_FU-1:0]               i_fu_valid,
  input  logic [PTR_W-1:0]                i_rr_ptr,
  output logic [NUM_FU-1:0]               o_grant,
  output logic [WR_PORTS-1:0][PTR_W-1:0]  o_port_idx,
  output logic [WR_PORTS-1:0]             o_port_valid,
  output logic [PTR_W-1:0]                o_next_ptr
);

  localparam int IDX_W = PTR_W + 1;
  localparam int CNT_W = $clog2(NUM_FU + 1);

  always_comb begin
    logic [IDX_W-1:0] sum;
    logic [PTR_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    o_grant      = '0;
    o_port_idx   = '0;
    o_port_valid = '0;
    o_next_ptr   = i_rr_ptr;
    cnt          = '0;
    sum          = '0;
    idx          = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      // rr_ptr + j stays below 2*NUM_FU, so one conditional subtract wraps it
      sum = {1'b0, i_rr_ptr} + IDX_W'(j);
      if (sum >= IDX_W'(NUM_FU)) sum = sum - IDX_W'(NUM_FU);
      idx = sum[PTR_W-1:0];
      if (i_fu_valid[idx] && (cnt < CNT_W'(WR_PORTS))) begin
        o_grant[idx] = 1'b1;
        for (int p = 0; p < WR_PORTS; p++) begin
          if (cnt == CNT_W'(p)) begin
            o_port_idx[p]   = idx;
            o_port_valid[p] = 1'b1;
          end
        end
        cnt        = cnt + CNT_W'(1);
        o_next_ptr = (idx == PTR_W'(NUM_FU - 1)) ? '0 : idx + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/rob_wb_arbiter.sv
// Writeback arbiter: round-robin selection of FU results onto registered ROB write ports.
// Optional ROB_WB_STATS_EN adds write/stall counters.
module rob_wb_arbiter
  import rob_pkg::*;
#(
  parameter int  NUM_FU   = 6,
  parameter int  WR_PORTS = ROB_WR_PORTS,
  parameter int  SLOT_W   = ROB_SLOT_W,
  parameter type T        = logic [31:0]
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic                            i_flush,
  input  logic [NUM_FU-1:0]               i_fu_valid,
  input  logic [NUM_FU-1:0][SLOT_W-1:0]   i_fu_slot,
  input  T     [NUM_FU-1:0]               i_fu_data,
  output logic [NUM_FU-1:0]               o_fu_ready,
  output logic [WR_PORTS-1:0][SLOT_W-1:0] o_write_slot,
  output logic [WR_PORTS-1:0]             o_write_valid,
  output T     [WR_PORTS-1:0]             o_write_data
`ifdef ROB_WB_STATS_EN
  ,
  output logic [31:0]                     o_stat_writes,
  output logic [31:0]                     o_stat_stalls
`endif
);

  localparam int PTR_W = $clog2(NUM_FU);

  logic [PTR_W-1:0]                r_rr_ptr;
  logic [WR_PORTS-1:0]             r_write_valid;
  logic [WR_PORTS-1:0][SLOT_W-1:0] r_write_slot;
  T     [WR_PORTS-1:0]             r_write_data;

  logic [NUM_FU-1:0]               w_grant;
  logic [WR_PORTS-1:0][PTR_W-1:0]  w_port_idx;
  logic [WR_PORTS-1:0]             w_port_valid;
  logic [PTR_W-1:0]                w_next_ptr;
  logic [WR_PORTS-1:0][SLOT_W-1:0] w_sel_slot;
  T     [WR_PORTS-1:0]             w_sel_data;

  rob_wb_select #(
    .NUM_FU   (NUM_FU),
    .WR_PORTS (WR_PORTS)
  ) u_select (
    .i_fu_valid   (i_fu_valid),
    .i_rr_ptr     (r_rr_ptr),
    .o_grant      (w_grant),
    .o_port_idx   (w_port_idx),
    .o_port_valid (w_port_valid),
    .o_next_ptr   (w_next_ptr)
  );

  // Flush vetoes every handshake in the cycle it is asserted
  assign o_fu_ready = w_grant & {NUM_FU{~i_flush}};

  genvar gi;
  generate
    for (gi = 0; gi < WR_PORTS; gi++) begin : g_port_mux
      assign w_sel_slot[gi] = i_fu_slot[w_port_idx[gi]];
      assign w_sel_data[gi] = i_fu_data[w_port_idx[gi]];
    end
  endgenerate

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rr_ptr      <= '0;
      r_write_valid <= '0;
      r_write_slot  <= '0;
      r_write_data  <= '0;
    end else begin
      r_write_slot <= w_sel_slot;
      r_write_data <= w_sel_data;
      if (i_flush) begin
        r_rr_ptr      <= '0;
        r_write_valid <= '0;
      end else begin
        r_rr_ptr      <= w_next_ptr;
        r_write_valid <= w_port_valid;
      end
    end
  end

  assign o_write_valid = r_write_valid;
  assign o_write_slot  = r_write_slot;
  assign o_write_data  = r_write_data;

`ifdef ROB_WB_STATS_EN
  logic [31:0] r_stat_writes;
  logic [31:0] r_stat_stalls;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_stat_writes <= '0;
      r_stat_stalls <= '0;
    end else begin
      r_stat_writes <= r_stat_writes + 32'($countones(o_fu_ready));
      if (!i_flush && ($countones(i_fu_valid) > WR_PORTS))
        r_stat_stalls <= r_stat_stalls + 32'd1;
    end
  end

  assign o_stat_writes = r_stat_writes;
  assign o_stat_stalls = r_stat_stalls;
`endif

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Scoreboard bench for rob_wb_arbiter (NUM_FU=6, WR_PORTS=4): directed cases then a random soak.
module tb_rob_wb_arbiter;
  localparam int NF = 6;
  localparam int WP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [NF-1:0]        fu_valid = '0;
  logic [NF-1:0][3:0]   fu_slot  = '0;
  logic [NF-1:0][31:0]  fu_data  = '0;
  logic [NF-1:0]        o_fu_ready;
  logic [WP-1:0][3:0]   o_write_slot;
  logic [WP-1:0]        o_write_valid;
  logic [WP-1:0][31:0]  o_write_data;
`ifdef ROB_WB_STATS_EN
  logic [31:0] o_stat_writes;
  logic [31:0] o_stat_stalls;
`endif

  rob_wb_arbiter #(.NUM_FU(NF), .WR_PORTS(WP), .SLOT_W(4), .T(logic [31:0])) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_flush       (flush),
    .i_fu_valid    (fu_valid),
    .i_fu_slot     (fu_slot),
    .i_fu_data     (fu_data),
    .o_fu_ready    (o_fu_ready),
    .o_write_slot  (o_write_slot),
    .o_write_valid (o_write_valid),
    .o_write_data  (o_write_data)
`ifdef ROB_WB_STATS_EN
    ,
    .o_stat_writes (o_stat_writes),
    .o_stat_stalls (o_stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WP-1:0]       wv;
    logic [WP-1:0][3:0]  ws;
    logic [WP-1:0][31:0] wd;
    logic [2:0]          ptr;
  } exp_t;

  exp_t        sbq[$];
  int          tests = 0;
  int          fails = 0;
  int          m_ptr = 0;
  logic [NF-1:0] m_grant = '0;
  int unsigned m_writes = 0;
  int unsigned m_stalls = 0;
  bit          soak_on = 1'b0;
  int          wait_cnt[NF];
  int          dly[NF];
  int          max_wait = 0;
  int          obs_writes = 0;
  int          exp_acc = 0;
  logic [31:0] tag = 32'h1000_0000;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, obs, exp);
    end
  endtask

  // One arbitration cycle: predict at negedge, compare registered outputs just after posedge.
  task automatic step(input string name);
    exp_t e;
    logic [NF-1:0] er;
    int k, idx, last;
    @(negedge clk);
    er = '0; e.wv = '0; e.ws = '0; e.wd = '0; k = 0; last = 0;
    if (flush) begin
      m_ptr = 0;
    end else begin
      for (int j = 0; j < NF; j++) begin
        idx = (m_ptr + j) % NF;
        if (fu_valid[idx] && k < WP) begin
          er[idx] = 1'b1;
          e.wv[k] = 1'b1;
          e.ws[k] = fu_slot[idx];
          e.wd[k] = fu_data[idx];
          k++;
          last = idx;
        end
      end
      if (k > 0) m_ptr = (last + 1) % NF;
      m_writes += k;
      if ($countones(fu_valid) > WP) m_stalls++;
    end
    e.ptr = 3'(m_ptr);
    m_grant = er;
    check({name, ":ready"}, o_fu_ready, er);
    if (soak_on) begin
      exp_acc += k;
      for (int i = 0; i < NF; i++) begin
        if (fu_valid[i]) begin
          wait_cnt[i]++;
          if (o_fu_ready[i]) begin
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            wait_cnt[i] = 0;
          end
        end
      end
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check({name, ":wvalid"}, o_write_valid, e.wv);
    for (int p = 0; p < WP; p++) begin
      if (e.wv[p]) begin
        check($sformatf("%s:slot%0d", name, p), o_write_slot[p], e.ws[p]);
        check($sformatf("%s:data%0d", name, p), o_write_data[p], e.wd[p]);
      end
    end
    check({name, ":rr_ptr"}, dut.r_rr_ptr, e.ptr);
    if (soak_on) obs_writes += $countones(o_write_valid);
    $display("[TB] %s: valid=%b ready=%b wvalid=%b ptr=%0d", name, fu_valid, o_fu_ready,
             o_write_valid, dut.r_rr_ptr);
  endtask

  initial begin
    for (int i = 0; i < NF; i++) begin
      fu_slot[i] = 4'(i);
      fu_data[i] = 32'hD000_0000 + 32'(i);
      wait_cnt[i] = 0;
      dly[i] = 0;
    end
    fu_valid = 6'b111111;

    // Reset held with all FUs requesting
    repeat (2) @(posedge clk);
    #1;
    check("rst_wvalid", o_write_valid, 4'b0000);
    check("rst_ready", o_fu_ready, 6'b001111);
    rst = 1'b0;
    step("pre_rst");
    // Asynchronous reset in mid-cycle
    #2 rst = 1'b1;
    #1;
    check("async_rst_wvalid", o_write_valid, 4'b0000);
    check("async_rst_ptr", dut.r_rr_ptr, 3'd0);
    m_ptr = 0; m_writes = 0; m_stalls = 0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Oversubscription for two cycles
    step("over1");
    check("over1_data0", o_write_data[0], 32'hD000_0000);
    check("over1_data3", o_write_data[3], 32'hD000_0003);
    check("over1_ptr", dut.r_rr_ptr, 3'd4);
    step("over2");
    check("over2_data0", o_write_data[0], 32'hD000_0004);
    check("over2_data1", o_write_data[1], 32'hD000_0005);
    check("over2_data2", o_write_data[2], 32'hD000_0000);
    check("over2_data3", o_write_data[3], 32'hD000_0001);
    check("over2_ptr", dut.r_rr_ptr, 3'd2);
`ifdef ROB_WB_STATS_EN
    check("over_stat_writes", o_stat_writes, 32'd8);
    check("over_stat_stalls", o_stat_stalls, 32'd2);
`endif

    // Flush with three FUs pending, then they are granted
    fu_valid = 6'b010101;
    flush = 1'b1;
    step("flush");
    check("flush_wvalid", o_write_valid, 4'b0000);
    check("flush_ptr", dut.r_rr_ptr, 3'd0);
    flush = 1'b0;
    step("post_flush");
    check("post_flush_wvalid", o_write_valid, 4'b0111);
    check("post_flush_data2", o_write_data[2], 32'hD000_0004);
    check("post_flush_ptr", dut.r_rr_ptr, 3'd5);

    // Idle cycle keeps the pointer
    fu_valid = 6'b000000;
    step("idle");
    check("idle_ptr", dut.r_rr_ptr, 3'd5);
    flush = 1'b1;
    step("flush2");
    flush = 1'b0;

    // Single request from FU 2
    fu_valid = 6'b000100;
    fu_slot[2] = 4'd5;
    fu_data[2] = 32'hA5;
    step("single");
    check("single_wvalid", o_write_valid, 4'b0001);
    check("single_slot", o_write_slot[0], 4'd5);
    check("single_data", o_write_data[0], 32'hA5);
    check("single_ptr", dut.r_rr_ptr, 3'd3);

    // Wrap packing from rr_ptr=4
    fu_valid = 6'b001000;
    step("to_ptr4");
    fu_valid = 6'b100011;
    step("wrap");
    check("wrap_wvalid", o_write_valid, 4'b0111);
    check("wrap_data0", o_write_data[0], 32'hD000_0005);
    check("wrap_data1", o_write_data[1], 32'hD000_0000);
    check("wrap_data2", o_write_data[2], 32'hD000_0001);
    check("wrap_ptr", dut.r_rr_ptr, 3'd2);

    // Random soak: FUs refill after random idle gaps
    fu_valid = '0;
    soak_on = 1'b1;
    for (int c = 0; c < 400; c++) begin
      step("soak");
      for (int i = 0; i < NF; i++) begin
        if (m_grant[i]) begin
          fu_valid[i] = 1'b0;
          dly[i] = $urandom_range(0, 2);
        end
        if (!fu_valid[i]) begin
          if (dly[i] == 0) begin
            fu_valid[i] = 1'b1;
            fu_slot[i] = 4'($urandom);
            fu_data[i] = tag;
            tag = tag + 32'd1;
          end else begin
            dly[i]--;
          end
        end
      end
    end
    soak_on = 1'b0;
    check("soak_writes", 64'(obs_writes), 64'(exp_acc));
    check("soak_starve", 64'(max_wait <= 2), 64'd1);
`ifdef ROB_WB_STATS_EN
    check("soak_stat_writes", o_stat_writes, m_writes);
    check("soak_stat_stalls", o_stat_stalls, m_stalls);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
